forwarding_scoreboard: RTL

- Parametrised successor to the pipeline's combinational forwarding unit.
- Owns a DEPTH-entry shift register that tracks each instruction's destination register and write/load attributes as it leaves EX.
- Produces per-operand forward selects for NUM_SRC EX-stage sources and a load-use stall for ID-stage sources.
- Keeps sticky hazard-error and saturating performance counters.
- Sits beside the ID/EX/MEM/WB pipeline registers and drives the ALU operand muxes and the hazard/stall logic.

---
 rtl/forwarding_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks EX-stage writers through DEPTH later stages, derives
// per-operand forward selects, a load-use stall, a sticky hazard flag and perf counters.
module forwarding_scoreboard #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       flush,
    input  logic                       ex_valid,
    input  logic                       ex_regwrite,
    input  logic                       ex_memread,
    input  logic [REG_W-1:0]           ex_rd,
    input  logic [NUM_SRC*REG_W-1:0]   ex_src,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic                       hazard_err,
    output logic [CNT_W-1:0]           fwd_count,
    output logic [CNT_W-1:0]           stall_count
);

    logic [DEPTH:1]   valid_reg;
    logic [DEPTH:1]   regwrite_reg;
    logic [DEPTH:1]   memread_reg;
    logic [REG_W-1:0] rd_reg [1:DEPTH];
    logic [DEPTH:1]   live;

    logic [NUM_SRC-1:0] stage1_hit;
    logic [NUM_SRC-1:0] id_hit;

    logic             hazard_err_reg;
    logic [CNT_W-1:0] fwd_count_reg;
    logic [CNT_W-1:0] stall_count_reg;
    logic             hazard_next;
    logic             fwd_any;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
            // Register 0 is hardwired, so an entry targeting it never forwards.
            assign live[gi] = valid_reg[gi] & regwrite_reg[gi] & (rd_reg[gi] != '0);

            if (gi == 1) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg[gi]    <= 1'b0;
                        regwrite_reg[gi] <= 1'b0;
                        memread_reg[gi]  <= 1'b0;
                        rd_reg[gi]       <= '0;
                    end else if (advance) begin
                        valid_reg[gi]    <= ex_valid & ~flush;
                        regwrite_reg[gi] <= ex_regwrite;
                        memread_reg[gi]  <= ex_memread;
                        rd_reg[gi]       <= ex_rd;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg[gi]    <= 1'b0;
                        regwrite_reg[gi] <= 1'b0;
                        memread_reg[gi]  <= 1'b0;
                        rd_reg[gi]       <= '0;
                    end else if (advance) begin
                        valid_reg[gi]    <= valid_reg[gi-1];
                        regwrite_reg[gi] <= regwrite_reg[gi-1];
                        memread_reg[gi]  <= memread_reg[gi-1];
                        rd_reg[gi]       <= rd_reg[gi-1];
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_SRC; gi++) begin : g_operand
            logic [SEL_W-1:0] sel;

            // Scan from the oldest stage so the nearest matching stage is written last.
            always_comb begin
                sel = '0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (live[k] && (rd_reg[k] == ex_src[gi*REG_W +: REG_W])) begin
                        sel = SEL_W'(k);
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
            assign stage1_hit[gi] = (sel == SEL_W'(1));
            assign id_hit[gi]     = id_src_used[gi] && (id_src[gi*REG_W +: REG_W] == ex_rd);
        end
    endgenerate

    assign stall = ex_valid & ex_memread & ex_regwrite & (ex_rd != '0) & ~flush & (|id_hit);

    // Forwarding from stage 1 out of a load means the load-use stall was missed.
    assign hazard_next = (|stage1_hit) & memread_reg[1];
    assign fwd_any     = |fwd_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_err_reg  <= 1'b0;
            fwd_count_reg   <= '0;
            stall_count_reg <= '0;
        end else if (advance) begin
            if (hazard_next) begin
                hazard_err_reg <= 1'b1;
            end
            if (fwd_any && (fwd_count_reg != '1)) begin
                fwd_count_reg <= fwd_count_reg + 1'b1;
            end
            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign hazard_err  = hazard_err_reg;
    assign fwd_count   = fwd_count_reg;
    assign stall_count = stall_count_reg;

endmodule
